ex_wb_skid_stage: RTL and testbench

- Pipeline stage between the execute datapath (shifter SLL/SRA/ROR and adder results) and register-file writeback.
- Holds up to two completed results in a 2-entry skid buffer with valid/ready on both sides.
- Commits architectural flags (Z, N, V) when a result retires, and provides a forwarding lookup for in-flight results.

---
 rtl/ex_wb_skid_stage.sv | 106 ++++++++++
 tb/tb_ex_wb_skid_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_skid_stage.sv
// Execute-to-writeback skid stage: 2-entry result FIFO, flag commit on retire,
// and a combinational forwarding lookup over buffered results.
module ex_wb_skid_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_we,
    input  logic              in_set_z,
    input  logic              in_set_nv,
    input  logic              in_v,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_we,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    input  logic [REG_W-1:0]  fwd_rs,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              we;
        logic              set_z;
        logic              set_nv;
        logic              v;
    } ent_t;

    ent_t       ent [2];
    ent_t       new_ent;
    logic [1:0] count;
    logic       acc, ret;

    assign new_ent    = '{result: in_result, rd: in_rd, we: in_we,
                          set_z: in_set_z, set_nv: in_set_nv, v: in_v};
    assign in_ready   = ~flush & (count != 2'd2);
    assign out_valid  = (count != 2'd0);
    assign acc        = in_valid & in_ready;
    assign ret        = out_valid & out_ready;
    // Unoccupied slots are always held at zero, so the head reads zero when empty.
    assign out_result = ent[0].result;
    assign out_rd     = ent[0].rd;
    assign out_we     = ent[0].we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            ent[0] <= '0;
            ent[1] <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            if (ret) begin
                if (ent[0].set_z)  flag_z <= (ent[0].result == '0);
                if (ent[0].set_nv) begin
                    flag_n <= ent[0].result[DATA_W-1];
                    flag_v <= ent[0].v;
                end
            end
            if (flush) begin
                count  <= 2'd0;
                ent[0] <= '0;
                ent[1] <= '0;
            end else if (acc && ret) begin
                // Only reachable with count==1: the new result replaces the head.
                ent[0] <= new_ent;
            end else if (ret) begin
                ent[0] <= ent[1];
                ent[1] <= '0;
                count  <= count - 2'd1;
            end else if (acc) begin
                if (count == 2'd0) ent[0] <= new_ent;
                else               ent[1] <= new_ent;
                count <= count + 2'd1;
            end
        end
    end

    // Younger slot checked first so the most recent producer wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_rs != '0) begin
            if (count == 2'd2 && ent[1].we && ent[1].rd == fwd_rs) begin
                fwd_hit  = 1'b1;
                fwd_data = ent[1].result;
            end else if (count != 2'd0 && ent[0].we && ent[0].rd == fwd_rs) begin
                fwd_hit  = 1'b1;
                fwd_data = ent[0].result;
            end
        end
    end

endmodule

// File: tb/tb_ex_wb_skid_stage.sv
// Bench for ex_wb_skid_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_wb_skid_stage;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_result = '0;
    logic [REG_W-1:0]  in_rd = '0;
    logic              in_we = 1'b0, in_set_z = 1'b0, in_set_nv = 1'b0, in_v = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic [REG_W-1:0]  out_rd;
    logic              out_we, flag_z, flag_n, flag_v;
    logic [REG_W-1:0]  fwd_rs = '0;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    ex_wb_skid_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_rd(in_rd), .in_we(in_we), .in_set_z(in_set_z), .in_set_nv(in_set_nv),
        .in_v(in_v), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic we, set_z, set_nv, v;
    } mdl_ent_t;

    mdl_ent_t q[$];
    logic     mz = 1'b0, mn = 1'b0, mv = 1'b0;
    int       n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance model and DUT one clock.
    task automatic step();
        logic exp_ir, exp_hit, ret, acc;
        logic [DATA_W-1:0] exp_fd;
        mdl_ent_t e;
        #1;
        exp_ir  = !flush && (q.size() < 2);
        exp_hit = 1'b0;
        exp_fd  = '0;
        if (fwd_rs != 0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].we && q[i].rd == fwd_rs) begin
                    exp_hit = 1'b1;
                    exp_fd  = q[i].result;
                    break;
                end
        chk("in_ready",   in_ready,   exp_ir);
        chk("out_valid",  out_valid,  q.size() != 0);
        chk("out_result", out_result, q.size() ? q[0].result : '0);
        chk("out_rd",     out_rd,     q.size() ? q[0].rd : '0);
        chk("out_we",     out_we,     q.size() ? q[0].we : 1'b0);
        chk("flag_z",     flag_z,     mz);
        chk("flag_n",     flag_n,     mn);
        chk("flag_v",     flag_v,     mv);
        chk("fwd_hit",    fwd_hit,    exp_hit);
        chk("fwd_data",   fwd_data,   exp_fd);
        ret = (q.size() != 0) && out_ready;
        acc = in_valid && exp_ir;
        e = '{result: in_result, rd: in_rd, we: in_we, set_z: in_set_z,
              set_nv: in_set_nv, v: in_v};
        @(posedge clk);
        if (ret) begin
            if (q[0].set_z)  mz = (q[0].result == 0);
            if (q[0].set_nv) begin mn = q[0].result[DATA_W-1]; mv = q[0].v; end
            void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (acc) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic push(input logic [DATA_W-1:0] r, input logic [REG_W-1:0] rd,
                        input logic we, input logic sz, input logic snv, input logic v);
        in_valid = 1'b1; in_result = r; in_rd = rd; in_we = we;
        in_set_z = sz; in_set_nv = snv; in_v = v;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst in_ready",  in_ready,  1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single pass
        out_ready = 1'b1;
        push(16'h0000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        #1;
        chk("t1 out_valid", out_valid, 1'b1);
        chk("t1 out_result", out_result, 16'h0000);
        chk("t1 out_rd", out_rd, 4'd3);
        step();
        #1;
        chk("t1 flag_z", flag_z, 1'b1);
        chk("t1 flag_n", flag_n, 1'b0);
        chk("t1 flag_v", flag_v, 1'b0);

        // 2: backpressure and full
        out_ready = 1'b0;
        push(16'h8001, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        push(16'h1234, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        #1;
        chk("t2 in_ready full", in_ready, 1'b0);
        chk("t2 head held", out_result, 16'h8001);
        out_ready = 1'b1;
        step();
        #1;
        chk("t2 flag_n", flag_n, 1'b1);
        chk("t2 flag_v", flag_v, 1'b1);
        chk("t2 second", out_result, 16'h1234);
        step();
        #1;
        chk("t2 drained", out_valid, 1'b0);

        // 3: simultaneous accept and retire at count 1 (0x0005 clears Z on retire)
        out_ready = 1'b0;
        push(16'h0005, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        out_ready = 1'b1;
        push(16'h0006, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t3 out_result", out_result, 16'h0006);
        chk("t3 in_ready (count 1)", in_ready, 1'b1);
        chk("t3 flag_z", flag_z, 1'b0);
        out_ready = 1'b1;
        step();

        // 4: forwarding priority
        out_ready = 1'b0;
        push(16'h00AA, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        push(16'h00BB, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        fwd_rs = 4'd5;
        #1;
        chk("t4 accepting not visible", fwd_data, 16'h00AA);
        step();
        in_valid = 1'b0;
        #1;
        chk("t4 fwd_hit", fwd_hit, 1'b1);
        chk("t4 fwd_data", fwd_data, 16'h00BB);
        fwd_rs = 4'd0;
        #1;
        chk("t4 r0 hit", fwd_hit, 1'b0);
        chk("t4 r0 data", fwd_data, 16'h0000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        push(16'h00AA, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        push(16'h00BB, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0; fwd_rs = 4'd5;
        #1;
        chk("t4 we0 hit", fwd_hit, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // 5: flush with retire
        push(16'h0000, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        push(16'h0007, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        flush = 1'b1; out_ready = 1'b1;
        push(16'h0009, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t5 in_ready flush", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5 flag_z", flag_z, 1'b1);
        chk("t5 out_valid", out_valid, 1'b0);

        // 6: async reset between edges
        out_ready = 1'b0;
        push(16'hF000, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        push(16'h0001, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 out_valid", out_valid, 1'b0);
        chk("t6 flag_z", flag_z, 1'b0);
        chk("t6 flag_n", flag_n, 1'b0);
        chk("t6 flag_v", flag_v, 1'b0);
        chk("t6 out_result", out_result, 16'h0000);
        q.delete(); mz = 1'b0; mn = 1'b0; mv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6 in_ready", in_ready, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_result = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            in_rd     = 4'($urandom_range(0, 3));
            in_we     = ($urandom_range(0, 3) != 0);
            in_set_z  = $urandom_range(0, 1);
            in_set_nv = $urandom_range(0, 1);
            in_v      = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            fwd_rs    = 4'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
